// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the MAC block: buffers two operand vectors, streams them
// pair-by-pair into the MAC, flushes its pipeline and captures the accumulated result.
module mac_operand_sequencer #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              start,
    input  logic [AW:0]       len,
    input  logic              abort,
    output logic              mac_rst,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_acc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int          DCW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW:0] LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    // ST_ABORT is the forced one-cycle MAC reset that follows a cancelled run.
    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_CAPTURE, ST_ABORT
    } state_e;

    state_e              state_q, state_d;
    logic [AW:0]         len_q, len_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DCW-1:0]      drain_q, drain_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                run_active;

    logic [DATA_W-1:0]   buf_a [DEPTH];
    logic [DATA_W-1:0]   buf_b [DEPTH];

    assign run_active = (state_q == ST_CLEAR) || (state_q == ST_STREAM) ||
                        (state_q == ST_DRAIN) || (state_q == ST_CAPTURE);

    // NOTE: the operand buffers carry no reset; their contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            buf_a[wr_addr] <= wr_a;
            buf_b[wr_addr] <= wr_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = (len_q == '0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM:  if ({1'b0, idx_q} == (len_q - LEN_ONE)) state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_q == DRAIN_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            ST_ABORT:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort && run_active) state_d = ST_ABORT;
    end

    always_comb begin
        len_d = len_q;
        if ((state_q == ST_IDLE) && start) len_d = (len > LEN_MAX) ? LEN_MAX : len;
        idx_d    = (state_q == ST_STREAM) ? idx_q + 1'b1 : '0;
        drain_d  = (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
        done_d   = (state_q == ST_CAPTURE) && !abort;
        result_d = done_d ? mac_acc : result_q;
    end

    always_comb begin
        busy       = run_active;
        mac_rst    = rst || (state_q == ST_CLEAR) || (state_q == ST_ABORT);
        mac_enable = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
        mac_a      = '0;
        mac_b      = '0;
        if (state_q == ST_STREAM) begin
            mac_a = buf_a[idx_q];
            mac_b = buf_b[idx_q];
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
